morse_char_buffer: RTL and testbench

//  Collects decoded Morse symbols (dot/dash) into a character and translates it to a 6-bit display code.

---
 rtl/morse_char_buffer_if.sv | 24 ++
 rtl/morse_char_buffer.sv | 173 +++++++++++++++++
 tb/tb_morse_char_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/morse_char_buffer_if.sv
// morse_char_buffer_if
//   Groups the symbol strobes, the ready handshake and the eight display
//   codes between the Morse decoder front end and morse_char_buffer.
//   master : drives sym_valid/sym_dash/char_end/word_end/clear, sees ready/char0..7
//   slave  : the buffer itself (morse_char_buffer)
interface morse_char_buffer_if;
  logic       sym_valid;
  logic       sym_dash;
  logic       char_end;
  logic       word_end;
  logic       clear;
  logic       ready;
  logic [5:0] char0, char1, char2, char3, char4, char5, char6, char7;

  modport master (
    output sym_valid, sym_dash, char_end, word_end, clear,
    input  ready, char0, char1, char2, char3, char4, char5, char6, char7
  );

  modport slave (
    input  sym_valid, sym_dash, char_end, word_end, clear,
    output ready, char0, char1, char2, char3, char4, char5, char6, char7
  );
endinterface

// File: rtl/morse_char_buffer.sv
// morse_char_buffer
//   Collects dot/dash symbols into a pending character, translates it to a
//   6-bit display code and shifts it into an 8-digit scrolling buffer
//   (char0 newest / rightmost, char7 oldest). Feeds sseg_driver I0..I7.
// Ports
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : morse_char_buffer_if.slave (strobes, clear, ready, char0..7)
// Configuration
//   MORSE_DIGITS_EN : when defined, five-symbol digit patterns decode to 0..9;
//                     otherwise they decode to ERR_CODE.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_COLLECT | accepting symbols and gap strobes (ready = 1)
// ST_SPACE   | one cycle: shifts in the word-gap blank (ready = 0)
module morse_char_buffer #(
  parameter logic [5:0] BLANK_CODE = 6'd36,
  parameter logic [5:0] ERR_CODE   = 6'd37
) (
  input logic                clk,
  input logic                reset_n,
  morse_char_buffer_if.slave bus
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_SPACE   = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] pat_q, pat_d;
  logic       ovf_q, ovf_d;
  logic [5:0] chars_q [8];
  logic [5:0] chars_d [8];

  logic       do_shift, do_clear;
  logic [5:0] shift_code;
  logic [2:0] cnt_a;
  logic [4:0] pat_a;
  logic       ovf_a;

  // Pattern bit k holds the k-th symbol received (1 = dash).
  function automatic logic [5:0] lookup(input logic [2:0] cnt, input logic [4:0] pat);
    logic [5:0] code;
    code = ERR_CODE;
    case ({cnt, pat})
      {3'd2, 5'b00010}: code = 6'd10; // A .-
      {3'd4, 5'b00001}: code = 6'd11; // B -...
      {3'd4, 5'b00101}: code = 6'd12; // C -.-.
      {3'd3, 5'b00001}: code = 6'd13; // D -..
      {3'd1, 5'b00000}: code = 6'd14; // E .
      {3'd4, 5'b00100}: code = 6'd15; // F ..-.
      {3'd3, 5'b00011}: code = 6'd16; // G --.
      {3'd4, 5'b00000}: code = 6'd17; // H ....
      {3'd2, 5'b00000}: code = 6'd18; // I ..
      {3'd4, 5'b01110}: code = 6'd19; // J .---
      {3'd3, 5'b00101}: code = 6'd20; // K -.-
      {3'd4, 5'b00010}: code = 6'd21; // L .-..
      {3'd2, 5'b00011}: code = 6'd22; // M --
      {3'd2, 5'b00001}: code = 6'd23; // N -.
      {3'd3, 5'b00111}: code = 6'd24; // O ---
      {3'd4, 5'b00110}: code = 6'd25; // P .--.
      {3'd4, 5'b01011}: code = 6'd26; // Q --.-
      {3'd3, 5'b00010}: code = 6'd27; // R .-.
      {3'd3, 5'b00000}: code = 6'd28; // S ...
      {3'd1, 5'b00001}: code = 6'd29; // T -
      {3'd3, 5'b00100}: code = 6'd30; // U ..-
      {3'd4, 5'b01000}: code = 6'd31; // V ...-
      {3'd3, 5'b00110}: code = 6'd32; // W .--
      {3'd4, 5'b01001}: code = 6'd33; // X -..-
      {3'd4, 5'b01101}: code = 6'd34; // Y -.--
      {3'd4, 5'b00011}: code = 6'd35; // Z --..
`ifdef MORSE_DIGITS_EN
      {3'd5, 5'b11111}: code = 6'd0;  // -----
      {3'd5, 5'b11110}: code = 6'd1;  // .----
      {3'd5, 5'b11100}: code = 6'd2;  // ..---
      {3'd5, 5'b11000}: code = 6'd3;  // ...--
      {3'd5, 5'b10000}: code = 6'd4;  // ....-
      {3'd5, 5'b00000}: code = 6'd5;  // .....
      {3'd5, 5'b00001}: code = 6'd6;  // -....
      {3'd5, 5'b00011}: code = 6'd7;  // --...
      {3'd5, 5'b00111}: code = 6'd8;  // ---..
      {3'd5, 5'b01111}: code = 6'd9;  // ----.
`endif
      default:          code = ERR_CODE;
    endcase
    return code;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    ovf_d      = ovf_q;
    do_shift   = 1'b0;
    do_clear   = 1'b0;
    shift_code = BLANK_CODE;
    cnt_a      = cnt_q;
    pat_a      = pat_q;
    ovf_a      = ovf_q;

    if (bus.clear) begin
      do_clear = 1'b1;
      cnt_d    = 3'd0;
      pat_d    = 5'd0;
      ovf_d    = 1'b0;
      state_d  = ST_COLLECT;
    end else if (state_q == ST_SPACE) begin
      // Strobes are dropped here; only the blank is shifted in.
      do_shift = 1'b1;
      state_d  = ST_COLLECT;
    end else begin
      // A symbol arriving with a gap strobe is appended before the commit.
      if (bus.sym_valid) begin
        if (cnt_q < 3'd5) begin
          pat_a = pat_q | ({4'b0000, bus.sym_dash} << cnt_q);
          cnt_a = cnt_q + 3'd1;
        end else begin
          ovf_a = 1'b1;
        end
      end
      cnt_d = cnt_a;
      pat_d = pat_a;
      ovf_d = ovf_a;

      if ((bus.char_end || bus.word_end) && (cnt_a != 3'd0)) begin
        do_shift   = 1'b1;
        shift_code = ovf_a ? ERR_CODE : lookup(cnt_a, pat_a);
        cnt_d      = 3'd0;
        pat_d      = 5'd0;
        ovf_d      = 1'b0;
        if (bus.word_end) state_d = ST_SPACE;
      end else if (bus.word_end && (chars_q[0] != BLANK_CODE)) begin
        do_shift = 1'b1;
      end
    end

    for (int i = 0; i < 8; i++) chars_d[i] = chars_q[i];
    if (do_clear) begin
      for (int i = 0; i < 8; i++) chars_d[i] = BLANK_CODE;
    end else if (do_shift) begin
      chars_d[0] = shift_code;
      for (int i = 1; i < 8; i++) chars_d[i] = chars_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_COLLECT;
      cnt_q   <= 3'd0;
      pat_q   <= 5'd0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 8; i++) chars_q[i] <= BLANK_CODE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < 8; i++) chars_q[i] <= chars_d[i];
    end
  end

  assign bus.ready = (state_q == ST_COLLECT);
  assign bus.char0 = chars_q[0];
  assign bus.char1 = chars_q[1];
  assign bus.char2 = chars_q[2];
  assign bus.char3 = chars_q[3];
  assign bus.char4 = chars_q[4];
  assign bus.char5 = chars_q[5];
  assign bus.char6 = chars_q[6];
  assign bus.char7 = chars_q[7];

endmodule

// File: tb/tb_morse_char_buffer.sv
// tb_morse_char_buffer
//   Table of one-cycle stimulus records with the expected char0/char1/ready
//   after the edge, pushed to a scoreboard queue on drive and popped after
//   the edge; plus hand-written sequences for buffer depth, clear and
//   asynchronous reset.
module tb_morse_char_buffer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  morse_char_buffer_if bus ();

  morse_char_buffer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

`ifdef MORSE_DIGITS_EN
  localparam logic [5:0] DIG0 = 6'd0;
`else
  localparam logic [5:0] DIG0 = 6'd37;
`endif

  typedef struct {
    string      name;
    logic       sv, sd, ce, we, clr;
    logic [5:0] e0, e1;
    logic       erdy;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] e0, e1;
    logic       erdy;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] get_char(input int i);
    case (i)
      0: return bus.char0;
      1: return bus.char1;
      2: return bus.char2;
      3: return bus.char3;
      4: return bus.char4;
      5: return bus.char5;
      6: return bus.char6;
      default: return bus.char7;
    endcase
  endfunction

  function automatic vec_t mk(input string name, input logic sv, sd, ce, we, clr,
                              input logic [5:0] e0, e1, input logic erdy);
    vec_t v;
    v.name = name; v.sv = sv; v.sd = sd; v.ce = ce; v.we = we; v.clr = clr;
    v.e0 = e0; v.e1 = e1; v.erdy = erdy;
    return v;
  endfunction

  // Drive one cycle of strobes, let the edge take them, then idle the bus.
  task automatic drive(input logic sv, sd, ce, we, clr);
    bus.sym_valid = sv; bus.sym_dash = sd; bus.char_end = ce;
    bus.word_end = we; bus.clear = clr;
    @(posedge clk); #1;
    bus.sym_valid = 1'b0; bus.sym_dash = 1'b0; bus.char_end = 1'b0;
    bus.word_end = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    e.name = v.name; e.e0 = v.e0; e.e1 = v.e1; e.erdy = v.erdy;
    sbq.push_back(e);
    drive(v.sv, v.sd, v.ce, v.we, v.clr);
    e = sbq.pop_front();
    chk({e.name, ".char0"}, bus.char0, e.e0);
    chk({e.name, ".char1"}, bus.char1, e.e1);
    chk({e.name, ".ready"}, bus.ready, e.erdy);
  endtask

  // Nine letters for the depth test: symbol count, LSB-first pattern, code.
  int         l_cnt  [9] = '{1, 1, 2, 2, 2, 2, 3, 3, 3};
  logic [4:0] l_pat  [9] = '{5'b0, 5'b1, 5'b0, 5'b10, 5'b1, 5'b11, 5'b0, 5'b100, 5'b10};
  logic [5:0] l_code [9] = '{6'd14, 6'd29, 6'd18, 6'd10, 6'd23, 6'd22, 6'd28, 6'd30, 6'd27};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           name          sv sd ce we clr  e0     e1     rdy
    vecs.push_back(mk("a_dot",     1, 0, 0, 0, 0, 6'd36, 6'd36, 1));
    vecs.push_back(mk("a_dash",    1, 1, 0, 0, 0, 6'd36, 6'd36, 1));
    vecs.push_back(mk("a_commit",  0, 0, 1, 0, 0, 6'd10, 6'd36, 1));
    vecs.push_back(mk("b_s1",      1, 1, 0, 0, 0, 6'd10, 6'd36, 1));
    vecs.push_back(mk("b_s2",      1, 0, 0, 0, 0, 6'd10, 6'd36, 1));
    vecs.push_back(mk("b_s3",      1, 0, 0, 0, 0, 6'd10, 6'd36, 1));
    vecs.push_back(mk("b_s4",      1, 0, 0, 0, 0, 6'd10, 6'd36, 1));
    vecs.push_back(mk("b_commit",  0, 0, 1, 0, 0, 6'd11, 6'd10, 1));
    vecs.push_back(mk("e_same",    1, 0, 1, 0, 0, 6'd14, 6'd11, 1));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk("ovf_dot", 1, 0, 0, 0, 0, 6'd14, 6'd11, 1));
    vecs.push_back(mk("ovf_err",   0, 0, 1, 0, 0, 6'd37, 6'd14, 1));
    vecs.push_back(mk("a2_dot",    1, 0, 0, 0, 0, 6'd37, 6'd14, 1));
    vecs.push_back(mk("a2_dash",   1, 1, 0, 0, 0, 6'd37, 6'd14, 1));
    vecs.push_back(mk("a2_commit", 0, 0, 1, 0, 0, 6'd10, 6'd37, 1));
    vecs.push_back(mk("t_dash",    1, 1, 0, 0, 0, 6'd10, 6'd37, 1));
    vecs.push_back(mk("t_word",    0, 0, 0, 1, 0, 6'd29, 6'd10, 0));
    vecs.push_back(mk("space_drop",1, 0, 0, 0, 0, 6'd36, 6'd29, 1));
    vecs.push_back(mk("ce_empty",  0, 0, 1, 0, 0, 6'd36, 6'd29, 1));
    vecs.push_back(mk("dbl_blank", 0, 0, 0, 1, 0, 6'd36, 6'd29, 1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("d0_dash", 1, 1, 0, 0, 0, 6'd36, 6'd29, 1));
    vecs.push_back(mk("d0_commit", 0, 0, 1, 0, 0, DIG0,  6'd36, 1));
    vecs.push_back(mk("cw_dot",    1, 0, 0, 0, 0, DIG0,  6'd36, 1));
    vecs.push_back(mk("ce_we",     0, 0, 1, 1, 0, 6'd14, DIG0,  0));
    vecs.push_back(mk("ce_we_sp",  0, 0, 0, 0, 0, 6'd36, 6'd14, 1));
    vecs.push_back(mk("t2_dash",   1, 1, 0, 0, 0, 6'd36, 6'd14, 1));
    vecs.push_back(mk("t2_commit", 0, 0, 1, 0, 0, 6'd29, 6'd36, 1));
    vecs.push_back(mk("we_direct", 0, 0, 0, 1, 0, 6'd36, 6'd29, 1));
    vecs.push_back(mk("clr_dot",   1, 0, 0, 0, 0, 6'd36, 6'd29, 1));
    vecs.push_back(mk("clr_prio",  1, 0, 1, 0, 1, 6'd36, 6'd36, 1));
    vecs.push_back(mk("clr_cnt",   0, 0, 1, 0, 0, 6'd36, 6'd36, 1));

    bus.sym_valid = 1'b0; bus.sym_dash = 1'b0; bus.char_end = 1'b0;
    bus.word_end = 1'b0; bus.clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) chk($sformatf("reset.char%0d", i), get_char(i), 6'd36);
    chk("reset.ready", bus.ready, 1'b1);

    foreach (vecs[i]) apply(vecs[i]);
    chk("sb_empty", sbq.size(), 0);

    // Nine letters: the first one must fall off the end of the buffer.
    for (int j = 0; j < 9; j++) begin
      for (int k = 0; k < l_cnt[j]; k++) drive(1'b1, l_pat[j][k], 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("depth.char%0d", i), get_char(i), l_code[8-i]);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("clear.char%0d", i), get_char(i), 6'd36);

    // Asynchronous reset while in SPACE: takes effect without a clock edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pre_rst.char0", bus.char0, 6'd10);
    chk("pre_rst.ready", bus.ready, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst.ready", bus.ready, 1'b1);
    chk("async_rst.char0", bus.char0, 6'd36);
    chk("async_rst.char1", bus.char1, 6'd36);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Pending symbols must not survive a reset.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset_n = 1'b0;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_pending.char0", bus.char0, 6'd36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
